tx_packet_arbiter: RTL and testbench



---
 rtl/ucaspian_tx_pkg.sv | 32 +++
 rtl/tx_packet_arbiter_rr_pick.sv | 38 +++
 rtl/tx_packet_arbiter.sv | 158 +++++++++++++++
 tb/tb_tx_packet_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ucaspian_tx_pkg.sv
// ----------------------------------------------------------------------------
// ucaspian_tx_pkg
// Shared definitions for the host-facing TX packet arbiter.
//   tx_arb_state_t : arbiter FSM states (IDLE, SEND)
//   TX_SRC_*       : fixed source indices of the core-side packet builders
//   TX_MAX_LEN     : default maximum packet length in bytes
//   clamp_len()    : maps a requested length onto the legal 1..max range
// ----------------------------------------------------------------------------
package ucaspian_tx_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_arb_state_t;

  localparam int TX_SRC_FIRE   = 0;
  localparam int TX_SRC_ACK    = 1;
  localparam int TX_SRC_TIME   = 2;
  localparam int TX_SRC_METRIC = 3;

  localparam int TX_MAX_LEN = 4;

  // A zero or oversized length means "full packet".
  function automatic int clamp_len(input int len, input int max_len);
    if ((len == 0) || (len > max_len)) begin
      return max_len;
    end else begin
      return len;
    end
  endfunction

endpackage

// File: rtl/tx_packet_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector: returns the first asserted request
// found scanning upward from rr_ptr_i, wrapping at NUM_REQ.
//   req_i     : request vector
//   rr_ptr_i  : index with highest priority this cycle
//   winner_o  : selected index (0 when nothing is requested)
//   any_req_o : at least one request is asserted
// ----------------------------------------------------------------------------
module rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic [IDX_W-1:0]   winner_o,
  output logic               any_req_o
);

  int idx_s;

  // Scan from the farthest offset down so the nearest request overrides.
  always_comb begin
    winner_o  = '0;
    any_req_o = 1'b0;
    idx_s     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx_s = (int'(rr_ptr_i) + k) % NUM_REQ;
      if (req_i[idx_s]) begin
        winner_o  = IDX_W'(idx_s);
        any_req_o = 1'b1;
      end else begin
        any_req_o = any_req_o;
      end
    end
  end

endmodule

// File: rtl/tx_packet_arbiter.sv
// ----------------------------------------------------------------------------
// tx_packet_arbiter
// Shares the host TX byte stream between NUM_REQ packet sources. One source
// is granted at a time (round-robin) and its whole packet is streamed MSB
// byte first on a valid/ready interface.
//   clk, reset        : clock, synchronous active-high reset
//   req               : per-source request, held until req_done
//   req_len           : per-source length (0 or >MAX_LEN means MAX_LEN)
//   req_data          : per-source packet bytes, byte 0 = MSB of the slice
//   req_done          : one-hot pulse on the final-byte handshake
//   tx_data/vld/rdy   : byte stream to the packet interface
//   busy              : packet in flight
//   grant_id          : current or last granted source
// Optional (macro UCASPIAN_TX_ARB_STATS_EN):
//   pkt_count         : completed packets, wraps
//   stall_count       : SEND cycles without tx_rdy, saturates
// ----------------------------------------------------------------------------
module tx_packet_arbiter
  import ucaspian_tx_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int MAX_LEN = TX_MAX_LEN,
  parameter  int LEN_W   = 3,
  localparam int IDX_W   = $clog2(NUM_REQ),
  localparam int PKT_W   = MAX_LEN * 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*LEN_W-1:0]   req_len,
  input  logic [NUM_REQ*PKT_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_done,
  output logic [7:0]                 tx_data,
  output logic                       tx_vld,
  input  logic                       tx_rdy,
  output logic                       busy,
`ifdef UCASPIAN_TX_ARB_STATS_EN
  output logic [31:0]                pkt_count,
  output logic [31:0]                stall_count,
`endif
  output logic [IDX_W-1:0]           grant_id
);

  tx_arb_state_t      state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [PKT_W-1:0]   shift_q, shift_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;

  logic [IDX_W-1:0]   winner_s;
  logic               any_req_s;
  logic [LEN_W-1:0]   win_len_s;
  logic [PKT_W-1:0]   win_data_s;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req_i     (req),
    .rr_ptr_i  (rr_ptr_q),
    .winner_o  (winner_s),
    .any_req_o (any_req_s)
  );

  assign win_len_s  = req_len[int'(winner_s)*LEN_W +: LEN_W];
  assign win_data_s = req_data[int'(winner_s)*PKT_W +: PKT_W];

  // Next-state logic: grant and latch in IDLE, shift bytes out in SEND.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    req_done = '0;
    case (state_q)
      IDLE: begin
        if (any_req_s) begin
          shift_d  = win_data_s;
          cnt_d    = LEN_W'(clamp_len(int'(win_len_s), MAX_LEN));
          grant_d  = winner_s;
          rr_ptr_d = (winner_s == IDX_W'(NUM_REQ - 1)) ? '0 : winner_s + 1'b1;
          state_d  = SEND;
        end else begin
          state_d  = IDLE;
        end
      end
      SEND: begin
        if (tx_rdy) begin
          shift_d = shift_q << 4'd8;
          cnt_d   = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            // Done is combinational so the source sees it on the handshake.
            req_done[grant_q] = 1'b1;
            state_d           = IDLE;
          end else begin
            state_d           = SEND;
          end
        end else begin
          state_d = SEND;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any packet in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      shift_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
    end
  end

  assign tx_vld   = (state_q == SEND);
  assign busy     = (state_q == SEND);
  // Bus is driven to zero between packets rather than showing stale bytes.
  assign tx_data  = tx_vld ? shift_q[PKT_W-1 -: 8] : 8'h00;
  assign grant_id = grant_q;

`ifdef UCASPIAN_TX_ARB_STATS_EN
  logic [31:0] pkt_count_q;
  logic [31:0] stall_count_q;

  // Packet counter wraps; stall counter saturates at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_count_q   <= 32'd0;
      stall_count_q <= 32'd0;
    end else begin
      if (|req_done) begin
        pkt_count_q <= pkt_count_q + 32'd1;
      end else begin
        pkt_count_q <= pkt_count_q;
      end
      if ((state_q == SEND) && !tx_rdy && (stall_count_q != 32'hFFFF_FFFF)) begin
        stall_count_q <= stall_count_q + 32'd1;
      end else begin
        stall_count_q <= stall_count_q;
      end
    end
  end

  assign pkt_count   = pkt_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_tx_packet_arbiter.sv
// ----------------------------------------------------------------------------
// tb_tx_packet_arbiter
// Directed scenarios followed by randomized traffic, every cycle compared
// against a queue-based model of the arbiter. Stats ports are checked when
// UCASPIAN_TX_ARB_STATS_EN is defined.
// ----------------------------------------------------------------------------
module tb_tx_packet_arbiter;

  localparam int N  = 4;
  localparam int ML = 4;
  localparam int LW = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      req = '0;
  logic [N*LW-1:0]   req_len;
  logic [N*ML*8-1:0] req_data;
  logic [N-1:0]      req_done;
  logic [7:0]        tx_data;
  logic              tx_vld;
  logic              tx_rdy = 1'b1;
  logic              busy;
  logic [1:0]        grant_id;
`ifdef UCASPIAN_TX_ARB_STATS_EN
  logic [31:0]       pkt_count;
  logic [31:0]       stall_count;
`endif

  logic [LW-1:0] len_a [N];
  logic [31:0]   dat_a [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_len[i*LW +: LW]   = len_a[i];
      req_data[i*32 +: 32]  = dat_a[i];
    end
  end

  tx_packet_arbiter #(.NUM_REQ(N), .MAX_LEN(ML), .LEN_W(LW)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_len     (req_len),
    .req_data    (req_data),
    .req_done    (req_done),
    .tx_data     (tx_data),
    .tx_vld      (tx_vld),
    .tx_rdy      (tx_rdy),
    .busy        (busy),
`ifdef UCASPIAN_TX_ARB_STATS_EN
    .pkt_count   (pkt_count),
    .stall_count (stall_count),
`endif
    .grant_id    (grant_id)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model state: packet in flight as a queue of pending bytes.
  bit           started = 1'b0;
  bit           m_busy = 1'b0;
  int           m_gid = 0;
  int           m_rr = 0;
  logic [7:0]   m_q[$];
  int           m_pkt = 0;
  logic [31:0]  m_stall = 32'd0;
  logic [N-1:0] done_seen = '0;
  logic [N-1:0] exp_done;
  int           done_log[$];
  bit           found;
  int           src;
  int           plen;
  bit           auto_raise = 1'b0;
  bit           rdy_rand = 1'b0;

  always @(negedge clk) begin
    if (started) begin
      exp_done = '0;
      if (m_busy && tx_rdy && (m_q.size() == 1)) exp_done[m_gid] = 1'b1;
      check("tx_vld",   32'(tx_vld),   32'(m_busy));
      check("busy",     32'(busy),     32'(m_busy));
      check("tx_data",  32'(tx_data),  m_busy ? 32'(m_q[0]) : 32'd0);
      check("req_done", 32'(req_done), 32'(exp_done));
      check("grant_id", 32'(grant_id), 32'(m_gid));
`ifdef UCASPIAN_TX_ARB_STATS_EN
      check("pkt_count",   pkt_count,   32'(m_pkt));
      check("stall_count", stall_count, m_stall);
`endif
      if (req_done != '0) done_log.push_back(int'(grant_id));
      done_seen = done_seen | exp_done;
      // Predict the effect of the coming edge.
      if (reset) begin
        m_busy = 1'b0; m_q.delete(); m_gid = 0; m_rr = 0; m_pkt = 0; m_stall = 32'd0;
      end else if (m_busy) begin
        if (!tx_rdy) begin
          if (m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
        end else begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) begin
            m_busy = 1'b0;
            m_pkt++;
          end
        end
      end else begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          src = (m_rr + k) % N;
          if (!found && req[src]) begin
            found  = 1'b1;
            m_gid  = src;
            m_rr   = (src + 1) % N;
            plen   = int'(len_a[src]);
            if (plen == 0 || plen > ML) plen = ML;
            for (int j = 0; j < plen; j++) m_q.push_back(dat_a[src][31-8*j -: 8]);
            m_busy = 1'b1;
          end
        end
      end
    end
  end

  // One clock: sources drop req after their done, optional random traffic.
  task automatic cyc();
    @(posedge clk);
    #1;
    started = 1'b1;
    for (int i = 0; i < N; i++) if (done_seen[i]) req[i] = 1'b0;
    done_seen = '0;
    if (auto_raise) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i]   = 1'b1;
          len_a[i] = LW'($urandom_range(0, 7));
          dat_a[i] = $urandom;
        end
      end
    end
    if (rdy_rand) tx_rdy = ($urandom_range(0, 9) < 7);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((req != '0 || m_busy) && n < budget) begin
      cyc();
      n++;
    end
    check("idle_within_budget", 32'(n < budget), 32'd1);
    cyc();
  endtask

  bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  bit rearmed;
  int n;
  int rr_exp [5] = '{0, 1, 2, 3, 0};

  initial begin
    for (int i = 0; i < N; i++) begin
      len_a[i] = LW'(1);
      dat_a[i] = 32'd0;
    end
    reset = 1'b1; cyc(); cyc(); reset = 1'b0;

    // Single packet from source 2, three bytes.
    done_log.delete();
    len_a[2] = 3'd3; dat_a[2] = 32'hA1B2C35A; req[2] = 1'b1;
    wait_idle(20);
    check("single_done_cnt", 32'(done_log.size()), 32'd1);
    if (done_log.size() == 1) check("single_done_src", 32'(done_log[0]), 32'd2);

    // Round-robin with source 0 re-requesting immediately.
    reset = 1'b1; cyc(); reset = 1'b0;
    done_log.delete();
    for (int i = 0; i < N; i++) begin
      len_a[i] = 3'd1;
      dat_a[i] = {8'(8'h10 * (i + 1)), 24'h000000};
    end
    req = 4'hF; rearmed = 1'b0; n = 0;
    while (done_log.size() < 5 && n < 60) begin
      cyc();
      n++;
      if (!req[0] && !rearmed) begin
        req[0]  = 1'b1;
        rearmed = 1'b1;
      end
    end
    wait_idle(20);
    check("rr_done_cnt", 32'(done_log.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < done_log.size()) check("rr_order", 32'(done_log[i]), 32'(rr_exp[i]));

    // Backpressure pattern on a 4-byte packet.
    done_log.delete();
    len_a[0] = 3'd4; dat_a[0] = 32'h11223344; req[0] = 1'b1;
    cyc();
    for (int k = 0; k < 7; k++) begin
      tx_rdy = pat[k];
      cyc();
    end
    tx_rdy = 1'b1;
    wait_idle(20);
    check("bp_done_cnt", 32'(done_log.size()), 32'd1);

    // Length clamp: 0 and 7 both mean four bytes.
    done_log.delete();
    len_a[1] = 3'd0; dat_a[1] = 32'hDEADBEEF; req[1] = 1'b1;
    wait_idle(20);
    len_a[1] = 3'd7; req[1] = 1'b1;
    wait_idle(20);
    check("clamp_done_cnt", 32'(done_log.size()), 32'd2);

    // Reset after the second byte handshake of a 4-byte packet.
    done_log.delete();
    len_a[3] = 3'd4; dat_a[3] = 32'h55667788; req[3] = 1'b1;
    cyc(); cyc(); cyc();
    reset = 1'b1; cyc(); reset = 1'b0;
    check("rst_no_done", 32'(done_log.size()), 32'd0);
    len_a[1] = 3'd2; dat_a[1] = 32'h9ABC0000; req[1] = 1'b1;
    wait_idle(30);
    check("rst_done_cnt", 32'(done_log.size()), 32'd2);
    if (done_log.size() == 2) begin
      check("rst_first_src",  32'(done_log[0]), 32'd1);
      check("rst_second_src", 32'(done_log[1]), 32'd3);
    end

    // Randomized traffic and backpressure.
    auto_raise = 1'b1; rdy_rand = 1'b1;
    repeat (1500) cyc();
    auto_raise = 1'b0; rdy_rand = 1'b0; tx_rdy = 1'b1;
    wait_idle(200);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
